// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// pwm_capture_if : PWM input and measurement result bundle for pwm_capture
// Rev 1.0
// ============================================================================
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [2:0]       duty_code;
  logic             timeout;
  logic             stuck_level;
  logic             overrun;

  modport master (
    output pwm_in,
    input  meas_valid, high_cnt, period_cnt, duty_code, timeout, stuck_level, overrun
  );

  modport slave (
    input  pwm_in,
    output meas_valid, high_cnt, period_cnt, duty_code, timeout, stuck_level, overrun
  );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : measures PWM high time and period, reports 3-bit duty code
// Rev 1.0
// ============================================================================
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 2**CNT_W - 1
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOUT_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;

  logic             div_busy;
  logic [1:0]       div_step;
  logic [CNT_W:0]   rem;
  logic [1:0]       q;
  logic [CNT_W-1:0] div_h;
  logic [CNT_W-1:0] div_p;

  logic             rise;
  logic             fall;
  logic [CNT_W:0]   rem_sh;
  logic             rem_ge;
  logic [2:0]       q_nxt;
  logic             div_done;
  logic             lat_hi;
  logic             load_div;
  logic             set_ovr;
  logic             tout_emit;
  logic             clr_tout;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign rem_sh   = rem << 1;
  assign rem_ge   = (rem_sh >= {1'b0, div_p});
  assign q_nxt    = {q, rem_ge};
  assign div_done = div_busy && (div_step == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_hi    = 1'b0;
    load_div  = 1'b0;
    set_ovr   = 1'b0;
    tout_emit = 1'b0;
    clr_tout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          clr_tout  = 1'b1;
          state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          lat_hi    = 1'b1;
          state_nxt = ST_LOW;
        end else if (cnt >= TOUT_LIM) begin
          state_nxt = ST_TOUT;
        end
      end
      ST_LOW: begin
        if (rise) begin
          load_div  = ~div_busy;
          set_ovr   = div_busy;
          state_nxt = ST_HIGH;
        end else if (cnt >= TOUT_LIM) begin
          state_nxt = ST_TOUT;
        end
      end
      ST_TOUT: begin
        // A finishing divide owns the output registers this cycle; report the timeout next.
        if (!div_done) begin
          tout_emit = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      s3              <= 1'b0;
      cnt             <= '0;
      hi_lat          <= '0;
      div_busy        <= 1'b0;
      div_step        <= 2'd0;
      rem             <= '0;
      q               <= 2'd0;
      div_h           <= '0;
      div_p           <= '0;
      bus.meas_valid  <= 1'b0;
      bus.high_cnt    <= '0;
      bus.period_cnt  <= '0;
      bus.duty_code   <= 3'd0;
      bus.timeout     <= 1'b0;
      bus.stuck_level <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;

      if (rise) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      if (lat_hi) begin
        hi_lat <= cnt;
      end

      bus.meas_valid <= 1'b0;
      if (set_ovr) begin
        bus.overrun <= 1'b1;
      end
      if (clr_tout) begin
        bus.timeout <= 1'b0;
      end

      // Three restoring steps produce floor(8*H/P), MSB first.
      if (load_div) begin
        div_busy <= 1'b1;
        div_step <= 2'd0;
        rem      <= {1'b0, hi_lat};
        q        <= 2'd0;
        div_h    <= hi_lat;
        div_p    <= cnt;
      end else if (div_busy) begin
        rem      <= rem_ge ? (rem_sh - {1'b0, div_p}) : rem_sh;
        q        <= q_nxt[1:0];
        div_step <= div_step + 2'd1;
        if (div_done) begin
          div_busy       <= 1'b0;
          bus.meas_valid <= 1'b1;
          bus.high_cnt   <= div_h;
          bus.period_cnt <= div_p;
          bus.duty_code  <= q_nxt;
        end
      end

      if (tout_emit) begin
        bus.meas_valid  <= 1'b1;
        bus.timeout     <= 1'b1;
        bus.stuck_level <= s2;
        bus.duty_code   <= s2 ? 3'd7 : 3'd0;
        bus.high_cnt    <= '0;
        bus.period_cnt  <= '0;
      end
    end
  end

endmodule
`default_nettype wire
